// File: rtl/multi_cycle_logic_unit.sv
// Slice-serial bitwise logic unit: AND/OR/XOR/NOR of two WIDTH-bit operands,
// SLICE bits per clock, LSB slice first, with start/busy/done handshake and zero flag.
module multi_cycle_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int NPAD   = 2 ** IW;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [IW-1:0]    idx;

  logic [SLICE-1:0] a_sl [NPAD];
  logic [SLICE-1:0] b_sl [NPAD];
  logic [SLICE-1:0] res_s;
  logic [WIDTH-1:0] out_next;

  // Operands reshaped into a power-of-two slice array so idx selects without range checks.
  for (genvar g = 0; g < NPAD; g++) begin : g_sl
    if (g < NSLICE) begin : g_real
      assign a_sl[g] = a_q[g*SLICE +: SLICE];
      assign b_sl[g] = b_q[g*SLICE +: SLICE];
      assign out_next[g*SLICE +: SLICE] = (idx == IW'(g)) ? res_s : out[g*SLICE +: SLICE];
    end else begin : g_pad
      assign a_sl[g] = '0;
      assign b_sl[g] = '0;
    end
  end

  always_comb begin
    res_s = '0;
    case (op_q)
      2'b00:   res_s = a_sl[idx] & b_sl[idx];
      2'b01:   res_s = a_sl[idx] | b_sl[idx];
      2'b10:   res_s = a_sl[idx] ^ b_sl[idx];
      default: res_s = ~(a_sl[idx] | b_sl[idx]);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      zero  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            idx   <= '0;
            out   <= '0;
            zero  <= 1'b0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          out <= out_next;
          if (idx == LAST) begin
            // Zero flag covers the slice being written on this same edge.
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            zero  <= (out_next == '0);
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
